// File: rtl/asteroid_split_tree.sv
// Asteroid split-tree controller: slot lifecycle, serial BCD scoring,
// level counter and extra-life pulse for SIZES sizes over 2**(SIZES-1) slots.
module asteroid_split_tree #(
   parameter int SIZES = 3,
   parameter int T_NUM = 4,
   parameter logic [12*SIZES-1:0] PTS_BCD = 36'h100_050_020,
   parameter int SCORE_DIGITS = 5,
   parameter int BONUS_DIGIT = 4,
   localparam int NSLOT = 2**(SIZES-1),
   localparam int SW = (SIZES > 1) ? $clog2(SIZES) : 1,
   localparam int PW = (NSLOT > 1) ? $clog2(NSLOT) : 1,
   localparam int DW = 4*SCORE_DIGITS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                vsync,
   input  logic                game_continue,
   input  logic                new_level,
   input  logic [NSLOT-1:0]    slot_en,
   input  logic [T_NUM-1:0]    torpedo_en,
   output logic [T_NUM-1:0]    torpedo_hit,
   output logic [NSLOT-1:0]    slot_alive,
   output logic [NSLOT*SW-1:0] slot_size,
   output logic [NSLOT-1:0]    spawn,
   output logic [NSLOT*PW-1:0] spawn_parent,
   output logic [DW-1:0]       score_bcd,
   output logic                score_busy,
   output logic [7:0]          level,
   output logic                level_up,
   output logic                extra_life
);

   typedef enum logic {IDLE, SCORE} state_t;

   state_t              state;
   logic                pend;
   logic [NSLOT-1:0]    hit_acc;
   logic [NSLOT-1:0]    hit_now;
   logic [NSLOT-1:0]    hits;
   logic [PW-1:0]       idx;
   logic [11:0]         pts_q [NSLOT];
   logic                commit;
   logic                reseed;
   logic                any_pts;
   logic [NSLOT-1:0]    alive_n;
   logic [NSLOT-1:0]    spawn_n;
   logic [NSLOT*SW-1:0] size_n;
   logic [NSLOT*PW-1:0] par_n;
   logic [11:0]         pts_n [NSLOT];
   logic [DW-1:0]       sum_bcd;
   logic                bonus;

   function automatic logic [11:0] pts_of(input int s);
      pts_of = '0;
      for (int k = 0; k < SIZES; k++)
         if (s == k) pts_of = PTS_BCD[k*12 +: 12];
   endfunction

   assign torpedo_hit = torpedo_en & {T_NUM{|slot_en}};
   assign hit_now = slot_alive & slot_en
                  & {NSLOT{game_continue & (|torpedo_en)}};
   // hits in the vsync cycle itself still count at commit
   assign hits = (hit_acc | hit_now) & {NSLOT{game_continue}};
   assign commit = (state == IDLE) && (vsync || pend);
   assign score_busy = (state != IDLE);

   always_comb begin
      int s;
      logic [PW-1:0] c;
      s = 0;
      c = '0;
      alive_n = slot_alive;
      size_n = slot_size;
      spawn_n = '0;
      par_n = '0;
      any_pts = 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
         pts_n[i] = '0;
         if (hits[i]) begin
            s = int'(slot_size[i*SW +: SW]);
            pts_n[i] = pts_of(s);
            if (s < SIZES-1) begin
               // child index i+2**s is free while i < 2**s holds
               c = PW'(i + (1 << s));
               size_n[i*SW +: SW] = SW'(s + 1);
               size_n[c*SW +: SW] = SW'(s + 1);
               alive_n[c] = 1'b1;
               spawn_n[i] = 1'b1;
               spawn_n[c] = 1'b1;
               par_n[i*PW +: PW] = PW'(i);
               par_n[c*PW +: PW] = PW'(i);
            end else begin
               alive_n[i] = 1'b0;
            end
         end
         any_pts = any_pts | (pts_n[i] != 12'd0);
      end
      reseed = new_level | ~(|alive_n);
      if (reseed) begin
         alive_n = NSLOT'(1);
         size_n = '0;
         spawn_n = NSLOT'(1);
         par_n = '0;
      end
   end

   always_comb begin
      logic [3:0] a;
      logic [3:0] b;
      logic [4:0] sum;
      logic cy;
      logic [DW-1:0] addend;
      addend = DW'(pts_q[idx]);
      a = '0;
      b = '0;
      sum = '0;
      cy = 1'b0;
      sum_bcd = '0;
      bonus = 1'b0;
      for (int d = 0; d < SCORE_DIGITS; d++) begin
         a = score_bcd[4*d +: 4];
         b = addend[4*d +: 4];
         if (d == BONUS_DIGIT) bonus = cy | (b != 4'd0);
         sum = {1'b0, a} + {1'b0, b} + {4'd0, cy};
         if (sum > 5'd9) begin
            sum_bcd[4*d +: 4] = 4'(sum - 5'd10);
            cy = 1'b1;
         end else begin
            sum_bcd[4*d +: 4] = sum[3:0];
            cy = 1'b0;
         end
      end
      // overflow out of the top digit pins the score at all nines
      if (cy) begin
         sum_bcd = {SCORE_DIGITS{4'h9}};
         bonus = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pend <= 1'b0;
         hit_acc <= '0;
         idx <= '0;
         slot_alive <= NSLOT'(1);
         slot_size <= '0;
         spawn <= '0;
         spawn_parent <= '0;
         score_bcd <= '0;
         level <= '0;
         level_up <= 1'b0;
         extra_life <= 1'b0;
         for (int i = 0; i < NSLOT; i++) pts_q[i] <= '0;
      end else begin
         spawn <= '0;
         level_up <= 1'b0;
         extra_life <= 1'b0;
         hit_acc <= commit ? '0 : (hit_acc | hit_now);
         if (commit) pend <= 1'b0;
         else if (vsync && state != IDLE) pend <= 1'b1;
         unique case (state)
            IDLE: begin
               if (commit) begin
                  slot_alive <= alive_n;
                  slot_size <= size_n;
                  spawn <= spawn_n;
                  spawn_parent <= par_n;
                  for (int i = 0; i < NSLOT; i++) pts_q[i] <= pts_n[i];
                  if (reseed) begin
                     level <= level + 8'd1;
                     level_up <= 1'b1;
                  end
                  idx <= '0;
                  state <= any_pts ? SCORE : IDLE;
               end
            end
            SCORE: begin
               score_bcd <= sum_bcd;
               extra_life <= bonus;
               idx <= idx + 1'b1;
               if (idx == PW'(NSLOT-1)) state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_asteroid_split_tree.sv
// Bench for asteroid_split_tree: directed frames plus randomized frames
// checked against a frame-level model of the tree, score and levels.
module tb_asteroid_split_tree;

   logic        clk = 1'b0;
   logic        reset;
   logic        vsync;
   logic        game_continue;
   logic        new_level;
   logic [3:0]  slot_en;
   logic [3:0]  torpedo_en;
   logic [3:0]  torpedo_hit;
   logic [3:0]  slot_alive;
   logic [7:0]  slot_size;
   logic [3:0]  spawn;
   logic [7:0]  spawn_parent;
   logic [19:0] score_bcd;
   logic        score_busy;
   logic [7:0]  level;
   logic        level_up;
   logic        extra_life;

   int total = 0;
   int bad = 0;

   bit [3:0]   m_alive;
   int         m_size [4];
   int         m_score;
   int         m_level;
   bit [3:0]   m_hit;
   logic [3:0] e_spawn;
   logic [7:0] e_par;
   bit         e_lvlup;
   bit         e_busy;
   int         e_pulses;

   always #5 clk = ~clk;

   asteroid_split_tree dut (
      .clk(clk),
      .reset(reset),
      .vsync(vsync),
      .game_continue(game_continue),
      .new_level(new_level),
      .slot_en(slot_en),
      .torpedo_en(torpedo_en),
      .torpedo_hit(torpedo_hit),
      .slot_alive(slot_alive),
      .slot_size(slot_size),
      .spawn(spawn),
      .spawn_parent(spawn_parent),
      .score_bcd(score_bcd),
      .score_busy(score_busy),
      .level(level),
      .level_up(level_up),
      .extra_life(extra_life)
   );

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int x;
      r = '0;
      x = v;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] e_size();
      logic [7:0] r;
      for (int i = 0; i < 4; i++) r[2*i +: 2] = 2'(m_size[i]);
      return r;
   endfunction

   function automatic logic [7:0] slot_mask(input logic [3:0] m);
      logic [7:0] r;
      for (int i = 0; i < 4; i++) r[2*i +: 2] = {2{m[i]}};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_alive = 4'b0001;
      m_size = '{0, 0, 0, 0};
      m_score = 0;
      m_level = 0;
      m_hit = '0;
   endtask

   // one clock of stimulus; the model accumulates hits like a frame does
   task automatic cyc(input logic [3:0] se, input logic [3:0] te,
                      input bit gc, input bit vs, input bit nl);
      slot_en = se;
      torpedo_en = te;
      game_continue = gc;
      vsync = vs;
      new_level = nl;
      if (gc && te != 4'b0) m_hit = m_hit | (m_alive & se);
      tick();
   endtask

   task automatic model_commit(input bit gc, input bit nl);
      bit [3:0] h;
      bit [3:0] na;
      int ns [4];
      int pts [4];
      int c;
      int nv;
      h = gc ? m_hit : 4'b0;
      m_hit = '0;
      na = m_alive;
      ns = m_size;
      e_spawn = '0;
      e_par = '0;
      e_lvlup = 1'b0;
      e_busy = 1'b0;
      e_pulses = 0;
      for (int i = 0; i < 4; i++) begin
         pts[i] = 0;
         if (h[i]) begin
            pts[i] = (m_size[i] == 0) ? 20 : (m_size[i] == 1) ? 50 : 100;
            if (m_size[i] < 2) begin
               c = i + (1 << m_size[i]);
               ns[i] = m_size[i] + 1;
               ns[c] = m_size[i] + 1;
               na[c] = 1'b1;
               e_spawn[i] = 1'b1;
               e_spawn[c] = 1'b1;
               e_par[2*i +: 2] = 2'(i);
               e_par[2*c +: 2] = 2'(i);
            end else begin
               na[i] = 1'b0;
            end
         end
      end
      if (nl || na == 4'b0) begin
         na = 4'b0001;
         ns = '{0, 0, 0, 0};
         e_spawn = 4'b0001;
         e_par = '0;
         e_lvlup = 1'b1;
         m_level = (m_level + 1) % 256;
      end
      m_alive = na;
      m_size = ns;
      for (int i = 0; i < 4; i++) begin
         if (pts[i] > 0) begin
            e_busy = 1'b1;
            nv = m_score + pts[i];
            if (nv > 99999) nv = 99999;
            else if (nv / 10000 > m_score / 10000) e_pulses++;
            m_score = nv;
         end
      end
   endtask

   task automatic run_score(output int p);
      p = 0;
      repeat (5) begin
         cyc(4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
         if (extra_life === 1'b1) p++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      vsync = 1'b0;
      game_continue = 1'b0;
      new_level = 1'b0;
      slot_en = '0;
      torpedo_en = '0;
      repeat (3) tick();
      reset = 1'b0;
      model_reset();
      total++; if (slot_alive !== 4'b0001) begin bad++; $display("FAIL reset_alive got=%b want=0001", slot_alive); end
      total++; if (slot_size !== 8'h00) begin bad++; $display("FAIL reset_size got=%h want=00", slot_size); end
      total++; if (score_bcd !== 20'h00000) begin bad++; $display("FAIL reset_score got=%h want=00000", score_bcd); end
      total++; if (level !== 8'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
      total++; if ({score_busy, spawn, level_up, extra_life} !== 7'b0) begin bad++; $display("FAIL reset_pulses got=%b want=0", {score_busy, spawn, level_up, extra_life}); end
   endtask

   task automatic test_first_split();
      int p;
      cyc(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
      model_commit(1'b1, 1'b0);
      total++; if (slot_alive !== 4'b0011) begin bad++; $display("FAIL split1_alive got=%b want=0011", slot_alive); end
      total++; if ((slot_size & slot_mask(m_alive)) !== 8'b0000_0101) begin bad++; $display("FAIL split1_size got=%b want=00000101", slot_size & slot_mask(m_alive)); end
      total++; if (spawn !== 4'b0011) begin bad++; $display("FAIL split1_spawn got=%b want=0011", spawn); end
      total++; if ((spawn_parent & slot_mask(spawn)) !== 8'h00) begin bad++; $display("FAIL split1_parent got=%b want=0", spawn_parent); end
      total++; if (score_busy !== 1'b1) begin bad++; $display("FAIL split1_busy got=%b want=1", score_busy); end
      cyc(4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
      total++; if (spawn !== 4'b0) begin bad++; $display("FAIL split1_spawn_pulse got=%b want=0000", spawn); end
      run_score(p);
      total++; if (score_bcd !== 20'h00020) begin bad++; $display("FAIL split1_score got=%h want=00020", score_bcd); end
   endtask

   task automatic test_double_split();
      int p;
      cyc(4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
      model_commit(1'b1, 1'b0);
      total++; if (slot_alive !== 4'b1111) begin bad++; $display("FAIL split2_alive got=%b want=1111", slot_alive); end
      total++; if (slot_size !== 8'b10_10_10_10) begin bad++; $display("FAIL split2_size got=%b want=10101010", slot_size); end
      total++; if (spawn_parent !== 8'b01_00_01_00) begin bad++; $display("FAIL split2_parent got=%b want=01000100", spawn_parent); end
      run_score(p);
      total++; if (score_bcd !== to_bcd(m_score)) begin bad++; $display("FAIL split2_score got=%h want=%h", score_bcd, to_bcd(m_score)); end
   endtask

   task automatic test_clear_reseed();
      int p;
      cyc(4'b0111, 4'b1000, 1'b1, 1'b1, 1'b0);
      model_commit(1'b1, 1'b0);
      total++; if (slot_alive !== 4'b1000) begin bad++; $display("FAIL clear_alive got=%b want=1000", slot_alive); end
      run_score(p);
      cyc(4'b1000, 4'b0100, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
      model_commit(1'b1, 1'b0);
      total++; if (slot_alive !== 4'b0001 || slot_size[1:0] !== 2'd0) begin bad++; $display("FAIL reseed_alive got=%b/%b want=0001/00", slot_alive, slot_size[1:0]); end
      total++; if (level_up !== 1'b1 || level !== 8'd1) begin bad++; $display("FAIL reseed_level got=%b/%0d want=1/1", level_up, level); end
      total++; if (spawn !== 4'b0001) begin bad++; $display("FAIL reseed_spawn got=%b want=0001", spawn); end
      cyc(4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
      total++; if (level_up !== 1'b0) begin bad++; $display("FAIL reseed_pulse got=%b want=0", level_up); end
      run_score(p);
      total++; if (score_bcd !== 20'h00520) begin bad++; $display("FAIL reseed_score got=%h want=00520", score_bcd); end
   endtask

   task automatic test_no_continue();
      int p;
      slot_en = 4'b1111; torpedo_en = 4'b1111; game_continue = 1'b0; vsync = 1'b0; new_level = 1'b0;
      #1;
      total++; if (torpedo_hit !== 4'b1111) begin bad++; $display("FAIL nocont_thit_a got=%b want=1111", torpedo_hit); end
      tick();
      slot_en = 4'b0000; torpedo_en = 4'b0110;
      #1;
      total++; if (torpedo_hit !== 4'b0000) begin bad++; $display("FAIL nocont_thit_b got=%b want=0000", torpedo_hit); end
      tick();
      slot_en = 4'b0100; torpedo_en = 4'b1010;
      #1;
      total++; if (torpedo_hit !== 4'b1010) begin bad++; $display("FAIL nocont_thit_c got=%b want=1010", torpedo_hit); end
      tick();
      cyc(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0);
      model_commit(1'b0, 1'b0);
      total++; if (slot_alive !== m_alive || spawn !== 4'b0) begin bad++; $display("FAIL nocont_state got=%b/%b want=%b/0000", slot_alive, spawn, m_alive); end
      total++; if (score_busy !== 1'b0) begin bad++; $display("FAIL nocont_busy got=%b want=0", score_busy); end
      run_score(p);
      total++; if (score_bcd !== 20'h00520 || level !== 8'd1) begin bad++; $display("FAIL nocont_score got=%h/%0d want=00520/1", score_bcd, level); end
   endtask

   task automatic test_deferred();
      int p;
      cyc(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0);
      model_commit(1'b1, 1'b0);
      total++; if (score_busy !== 1'b1) begin bad++; $display("FAIL defer_busy got=%b want=1", score_busy); end
      cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      cyc(4'b0010, 4'b0001, 1'b1, 1'b1, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
      total++; if (slot_alive !== 4'b0011 || score_busy !== 1'b1) begin bad++; $display("FAIL defer_hold got=%b/%b want=0011/1", slot_alive, score_busy); end
      cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      total++; if (slot_alive !== 4'b0011 || score_busy !== 1'b0) begin bad++; $display("FAIL defer_idle got=%b/%b want=0011/0", slot_alive, score_busy); end
      cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      model_commit(1'b1, 1'b0);
      total++; if (slot_alive !== 4'b1011) begin bad++; $display("FAIL defer_commit got=%b want=1011", slot_alive); end
      total++; if (spawn !== 4'b1010 || (spawn_parent & slot_mask(spawn)) !== 8'b01_00_01_00) begin bad++; $display("FAIL defer_spawn got=%b/%b want=1010/01000100", spawn, spawn_parent & slot_mask(spawn)); end
      run_score(p);
      total++; if (score_bcd !== 20'h00590) begin bad++; $display("FAIL defer_score got=%h want=00590", score_bcd); end
   endtask

   task automatic test_random();
      int n;
      int p;
      logic [3:0] se;
      logic [3:0] te;
      bit gc;
      bit nl;
      for (int f = 0; f < 40; f++) begin
         n = $urandom_range(0, 5);
         for (int k = 0; k < n; k++) begin
            se = 4'($urandom);
            te = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
            gc = ($urandom_range(0, 3) != 0);
            cyc(se, te, gc, 1'b0, 1'b0);
         end
         se = 4'($urandom);
         te = 4'($urandom);
         gc = ($urandom_range(0, 3) != 0);
         nl = ($urandom_range(0, 7) == 0);
         cyc(se, te, gc, 1'b1, nl);
         model_commit(gc, nl);
         total++; if (slot_alive !== m_alive) begin bad++; $display("FAIL rand_alive f=%0d got=%b want=%b", f, slot_alive, m_alive); end
         total++; if ((slot_size & slot_mask(m_alive)) !== (e_size() & slot_mask(m_alive))) begin bad++; $display("FAIL rand_size f=%0d got=%b want=%b", f, slot_size & slot_mask(m_alive), e_size() & slot_mask(m_alive)); end
         total++; if (spawn !== e_spawn || (spawn_parent & slot_mask(e_spawn)) !== e_par) begin bad++; $display("FAIL rand_spawn f=%0d got=%b/%b want=%b/%b", f, spawn, spawn_parent, e_spawn, e_par); end
         total++; if (level !== 8'(m_level) || level_up !== e_lvlup) begin bad++; $display("FAIL rand_level f=%0d got=%0d/%b want=%0d/%b", f, level, level_up, m_level, e_lvlup); end
         total++; if (score_busy !== e_busy) begin bad++; $display("FAIL rand_busy f=%0d got=%b want=%b", f, score_busy, e_busy); end
         run_score(p);
         total++; if (score_bcd !== to_bcd(m_score) || p != e_pulses) begin bad++; $display("FAIL rand_score f=%0d got=%h/%0d want=%h/%0d", f, score_bcd, p, to_bcd(m_score), e_pulses); end
      end
   endtask

   // play full-hit frames across every 10000 boundary up to saturation
   task automatic test_bonus_saturate();
      int p;
      int fr;
      int sat;
      int tot_p;
      fr = 0;
      sat = 0;
      tot_p = 0;
      while (sat < 3 && fr < 1000) begin
         if (m_score == 99999) sat++;
         cyc(4'b1111, 4'b0001, 1'b1, 1'b1, 1'b0);
         model_commit(1'b1, 1'b0);
         total++; if (slot_alive !== m_alive || level !== 8'(m_level)) begin bad++; $display("FAIL bonus_state fr=%0d got=%b/%0d want=%b/%0d", fr, slot_alive, level, m_alive, m_level); end
         run_score(p);
         tot_p += p;
         total++; if (score_bcd !== to_bcd(m_score)) begin bad++; $display("FAIL bonus_score fr=%0d got=%h want=%h", fr, score_bcd, to_bcd(m_score)); end
         total++; if (p != e_pulses) begin bad++; $display("FAIL bonus_pulse fr=%0d got=%0d want=%0d", fr, p, e_pulses); end
         fr++;
      end
      total++; if (score_bcd !== 20'h99999) begin bad++; $display("FAIL sat_score got=%h want=99999", score_bcd); end
      total++; if (tot_p != 9) begin bad++; $display("FAIL bonus_total got=%0d want=9", tot_p); end
   endtask

   task automatic test_reset_mid();
      int p;
      cyc(4'b1111, 4'b0001, 1'b1, 1'b1, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      total++; if (score_bcd !== 20'h0 || score_busy !== 1'b0) begin bad++; $display("FAIL midrst_score got=%h/%b want=00000/0", score_bcd, score_busy); end
      total++; if (slot_alive !== 4'b0001 || level !== 8'd0) begin bad++; $display("FAIL midrst_state got=%b/%0d want=0001/0", slot_alive, level); end
      run_score(p);
      total++; if (score_bcd !== 20'h0 || extra_life !== 1'b0) begin bad++; $display("FAIL midrst_nopartial got=%h want=00000", score_bcd); end
      cyc(4'b0001, 4'b1000, 1'b1, 1'b1, 1'b0);
      model_commit(1'b1, 1'b0);
      run_score(p);
      total++; if (score_bcd !== 20'h00020 || slot_alive !== 4'b0011) begin bad++; $display("FAIL midrst_after got=%h/%b want=00020/0011", score_bcd, slot_alive); end
   endtask

   initial begin
      test_reset();
      test_first_split();
      test_double_split();
      test_clear_reseed();
      test_no_continue();
      test_deferred();
      test_random();
      test_bonus_saturate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
